div32_seq: RTL and testbench

Multi-cycle sequential 32-bit integer divider for the ALU32 datapath, built around one shared ripple subtractor. It accepts a dividend/divisor pair on a start pulse and runs restoring division, one quotient bit per clock. It reports quotient, remainder and divide-by-zero with a one-cycle done pulse. It sits beside the single-cycle ALU32 ops and supplies the DIV/REM results.

---
 rtl/alu32_pkg.sv | 6 +
 rtl/div32_sub.sv | 17 +
 rtl/div32_seq.sv | 128 ++++++++++++
 tb/tb_div32_seq.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/alu32_pkg.sv
// alu32_pkg: shared types and constants for the ALU32 datapath and its sequential divider.
package alu32_pkg;
   typedef enum logic [1:0] {IDLE, RUN, DONE} div_state_e;
   localparam int DIV_W = 32;
   localparam logic [DIV_W-1:0] DIV_DBZ_QUOT = '1;
endpackage

// File: rtl/div32_sub.sv
// div32_sub: W-bit ripple subtractor (a - b) as an inverted-b full-adder chain, carry-in 1.
module div32_sub #(
   parameter int W = 33
) (
   input  logic [W-1:0] a_i,
   input  logic [W-1:0] b_i,
   output logic [W-1:0] d_o,
   output logic         co_o
);
   logic [W:0] c;
   assign c[0] = 1'b1;
   for (genvar i = 0; i < W; i++) begin : g_fa
      assign d_o[i]  = a_i[i] ^ ~b_i[i] ^ c[i];
      assign c[i+1]  = (a_i[i] & ~b_i[i]) | (c[i] & (a_i[i] ^ ~b_i[i]));
   end
   assign co_o = c[W];
endmodule

// File: rtl/div32_seq.sv
// div32_seq: multi-cycle restoring divider, one quotient bit per clock on a shared subtractor.
// Signed operation (signed_op port) is built only when DIV32_SIGNED_EN is defined.
module div32_seq
   import alu32_pkg::*;
#(
   parameter int N = DIV_W
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [N-1:0] dividend,
   input  logic [N-1:0] divisor,
`ifdef DIV32_SIGNED_EN
   input  logic         signed_op,
`endif
   output logic         busy,
   output logic         done,
   output logic [N-1:0] quotient,
   output logic [N-1:0] remainder,
   output logic         dbz
);
   localparam int CW = $clog2(N) + 1;
   div_state_e  state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [N:0]  p_q, p_d, p_sh, trial, p_nx;
   logic [N-1:0] q_q, q_d, q_nx, dvs_q, dvs_d, quot_d, rem_d, mag_a, mag_b, fin_q, fin_r;
   logic        dbz_d, co, unused_p;
   assign unused_p = p_q[N];
   assign p_sh = {p_q[N-1:0], q_q[N-1]};
   div32_sub #(.W(N + 1)) u_sub (
      .a_i  (p_sh),
      .b_i  ({1'b0, dvs_q}),
      .d_o  (trial),
      .co_o (co)
   );
   assign p_nx = co ? trial : p_sh;
   assign q_nx = {q_q[N-2:0], co};
`ifdef DIV32_SIGNED_EN
   logic sa, sb, neg_q, neg_d, rneg_q, rneg_d;
   assign sa    = signed_op & dividend[N-1];
   assign sb    = signed_op & divisor[N-1];
   assign mag_a = sa ? -dividend : dividend;
   assign mag_b = sb ? -divisor : divisor;
   assign fin_q = neg_q ? -q_nx : q_nx;
   assign fin_r = rneg_q ? -p_nx[N-1:0] : p_nx[N-1:0];
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         neg_q  <= 1'b0;
         rneg_q <= 1'b0;
      end else begin
         neg_q  <= neg_d;
         rneg_q <= rneg_d;
      end
   always_comb begin
      neg_d  = neg_q;
      rneg_d = rneg_q;
      if (state_q != RUN && start && divisor != '0) begin
         neg_d  = sa ^ sb;
         rneg_d = sa;
      end
   end
`else
   assign mag_a = dividend;
   assign mag_b = divisor;
   assign fin_q = q_nx;
   assign fin_r = p_nx[N-1:0];
`endif
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         p_q       <= '0;
         q_q       <= '0;
         dvs_q     <= '0;
         quotient  <= '0;
         remainder <= '0;
         dbz       <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         p_q       <= p_d;
         q_q       <= q_d;
         dvs_q     <= dvs_d;
         quotient  <= quot_d;
         remainder <= rem_d;
         dbz       <= dbz_d;
      end
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      p_d     = p_q;
      q_d     = q_q;
      dvs_d   = dvs_q;
      quot_d  = quotient;
      rem_d   = remainder;
      dbz_d   = dbz;
      if (state_q == RUN) begin
         p_d   = p_nx;
         q_d   = q_nx;
         cnt_d = cnt_q - CW'(1);
         if (cnt_q == CW'(1)) begin
            state_d = DONE;
            quot_d  = fin_q;
            rem_d   = fin_r;
            dbz_d   = 1'b0;
         end
      end else if (start) begin
         if (divisor == '0) begin
            state_d = DONE;
            quot_d  = N'(DIV_DBZ_QUOT);
            rem_d   = dividend;
            dbz_d   = 1'b1;
         end else begin
            state_d = RUN;
            p_d     = '0;
            q_d     = mag_a;
            dvs_d   = mag_b;
            cnt_d   = CW'(N);
         end
      end else begin
         state_d = IDLE;
      end
   end
   always_comb begin
      busy = state_q == RUN;
      done = state_q == DONE;
   end
endmodule

// File: tb/tb_div32_seq.sv
// tb_div32_seq: directed and random checks of div32_seq against an arithmetic reference model.
module tb_div32_seq;
`ifdef DIV32_SIGNED_EN
   localparam bit SGN = 1'b1;
`else
   localparam bit SGN = 1'b0;
`endif
   logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, signed_op = 1'b0;
   logic [31:0] dividend = '0, divisor = '0, quotient, remainder;
   logic busy, done, dbz;
   int checks = 0, errors = 0;
   div32_seq dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .dividend  (dividend),
      .divisor   (divisor),
`ifdef DIV32_SIGNED_EN
      .signed_op (signed_op),
`endif
      .busy      (busy),
      .done      (done),
      .quotient  (quotient),
      .remainder (remainder),
      .dbz       (dbz)
   );
   always #5 clk = ~clk;
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask
   function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic sg,
                                 output logic [31:0] q, output logic [31:0] r, output logic z);
      longint sa, sb;
      z = (b == 0);
      if (b == 0) begin
         q = 32'hFFFF_FFFF;
         r = a;
      end else if (sg && SGN) begin
         sa = longint'($signed(a));
         sb = longint'($signed(b));
         q  = 32'(sa / sb);
         r  = 32'(sa % sb);
      end else begin
         q = a / b;
         r = a % b;
      end
   endfunction
   // Counts edges after the accepting edge until done; optionally pulses start at edge offset pulse_at.
   task automatic wait_done(input int pulse_at, input logic [31:0] held, output int n, output int bc,
                            output int hold_bad);
      n = 0;
      bc = 0;
      hold_bad = 0;
      while (!done && n < 200) begin
         bc += int'(busy);
         if (quotient !== held) hold_bad++;
         if (pulse_at >= 0) begin
            start    = (n == pulse_at);
            dividend = 32'd9;
            divisor  = 32'd9;
         end
         @(posedge clk);
         #1;
         n++;
      end
      if (pulse_at >= 0) start = 1'b0;
   endtask
   task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic sg, input int pulse_at);
      logic [31:0] eq, er, held;
      logic ez;
      int n, bc, hb;
      model(a, b, sg, eq, er, ez);
      held = quotient;
      @(negedge clk);
      start = 1'b1;
      dividend = a;
      divisor = b;
      signed_op = sg;
      @(posedge clk);
      #1;
      start = 1'b0;
      dividend = $urandom;
      divisor = $urandom;
      signed_op = 1'($urandom);
      wait_done(pulse_at, held, n, bc, hb);
      check({tag, " latency"}, 32'(n), (b == 0) ? 32'd0 : 32'd32);
      check({tag, " busy cycles"}, 32'(bc), (b == 0) ? 32'd0 : 32'd32);
      check({tag, " result hold"}, 32'(hb), 32'd0);
      check({tag, " quotient"}, quotient, eq);
      check({tag, " remainder"}, remainder, er);
      check({tag, " dbz"}, 32'(dbz), 32'(ez));
      @(posedge clk);
      #1;
      check({tag, " done pulse"}, 32'(done), 32'd0);
      check({tag, " quotient held"}, quotient, eq);
   endtask
   initial begin
      logic [31:0] eq, er, a, b;
      logic ez;
      int n, bc, hb;
      repeat (2) @(posedge clk);
      #1;
      check("reset busy", 32'(busy), 32'd0);
      check("reset done", 32'(done), 32'd0);
      check("reset quotient", quotient, 32'd0);
      check("reset remainder", remainder, 32'd0);
      check("reset dbz", 32'(dbz), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      run_op("100/7", 32'd100, 32'd7, 1'b0, -1);
      run_op("max/1", 32'hFFFF_FFFF, 32'd1, 1'b0, -1);
      run_op("5/0", 32'd5, 32'd0, 1'b0, -1);
      run_op("1000/3 with ignored start", 32'd1000, 32'd3, 1'b0, 10);
      // Abort 50/5 mid-run: everything must clear without waiting for a clock edge.
      @(negedge clk);
      start = 1'b1;
      dividend = 32'd50;
      divisor = 32'd5;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (14) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("abort busy", 32'(busy), 32'd0);
      check("abort done", 32'(done), 32'd0);
      check("abort quotient", quotient, 32'd0);
      check("abort remainder", remainder, 32'd0);
      check("abort dbz", 32'(dbz), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      run_op("50/5 after abort", 32'd50, 32'd5, 1'b0, -1);
      // Back-to-back: start stays high, second pair 9/2 accepted on the edge leaving DONE.
      model(32'd200, 32'd7, 1'b0, eq, er, ez);
      @(negedge clk);
      start = 1'b1;
      dividend = 32'd200;
      divisor = 32'd7;
      @(posedge clk);
      #1;
      dividend = 32'd9;
      divisor = 32'd2;
      wait_done(-1, quotient, n, bc, hb);
      check("b2b first latency", 32'(n), 32'd32);
      check("b2b first quotient", quotient, eq);
      check("b2b first remainder", remainder, er);
      @(posedge clk);
      #1;
      start = 1'b0;
      check("b2b second accepted busy", 32'(busy), 32'd1);
      check("b2b done low", 32'(done), 32'd0);
      wait_done(-1, quotient, n, bc, hb);
      check("b2b second latency", 32'(n), 32'd32);
      check("b2b second quotient", quotient, 32'd4);
      check("b2b second remainder", remainder, 32'd1);
      check("b2b second dbz", 32'(dbz), 32'd0);
`ifdef DIV32_SIGNED_EN
      run_op("signed -7/2", 32'hFFFF_FFF9, 32'd2, 1'b1, -1);
      run_op("signed min/-1", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, -1);
      run_op("signed -9/0", 32'hFFFF_FFF7, 32'd0, 1'b1, -1);
`endif
      for (int i = 0; i < 24; i++) begin
         a = $urandom;
         b = ($urandom_range(0, 7) == 0) ? 32'd0 :
             ($urandom_range(0, 1) == 1) ? 32'($urandom) : 32'($urandom_range(1, 1000));
         run_op($sformatf("random %0d", i), a, b, 1'($urandom), -1);
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
